// File: rtl/cpu_pkg.sv
// Shared constants and types for simple_cpu and its instruction sequencer.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 20;
  localparam int unsigned ADDR_BITS   = 5;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned OPC_BITS    = 4;
  localparam int unsigned ISSUE_GAP   = 3;
  localparam logic [OPC_BITS-1:0] HALT_OP = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    PAUSE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/prog_ram.sv
// Single-port program RAM with synchronous read; contents are not reset.
module prog_ram #(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Loads a program into RAM and issues it to the CPU one word at a time,
// with a fixed gap between issues, optional single-step and halt detection.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int unsigned ADDR_BITS   = cpu_pkg::ADDR_BITS,
  parameter int unsigned ISSUE_GAP   = cpu_pkg::ISSUE_GAP,
  parameter logic [3:0]  HALT_OP     = cpu_pkg::HALT_OP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [ADDR_BITS-1:0]   load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [ADDR_BITS:0]     prog_len,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   abort,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned LEN_BITS = ADDR_BITS + 1;
  localparam int unsigned GAP_BITS = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  seq_state_t             state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [GAP_BITS-1:0]    gap_q, gap_d;
  logic [LEN_BITS-1:0]    len_q, len_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;

  logic                   ram_we;
  logic [ADDR_BITS-1:0]   ram_addr;
  logic [INSTR_WIDTH-1:0] ram_rdata;

  // Loads only reach the RAM while the sequencer is not running, so the
  // shared port is free for program writes in IDLE/DONE.
  assign ram_we   = load_valid && ready_q;
  assign ram_addr = ram_we ? load_addr : pc_q;

  prog_ram #(
    .WIDTH     (INSTR_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_prog_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      gap_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    gap_d   = gap_q;
    len_d   = len_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d   = prog_len;
          pc_d    = '0;
          state_d = (prog_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        if (ram_rdata[INSTR_WIDTH-1 -: 4] == HALT_OP) begin
          state_d = DONE;
        end else begin
          instr_d = ram_rdata;
          valid_d = 1'b1;
          gap_d   = GAP_BITS'(ISSUE_GAP - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_BITS'(1);
        end else if (LEN_BITS'(pc_q) + LEN_BITS'(1) == len_q) begin
          state_d = DONE;
        end else begin
          pc_d    = pc_q + ADDR_BITS'(1);
          state_d = step_mode ? PAUSE : FETCH;
        end
      end
      PAUSE: if (step) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d = IDLE;
      pc_d    = '0;
      valid_d = 1'b0;
    end

    busy_d  = !(state_d == IDLE || state_d == DONE);
    done_d  = (state_d == DONE);
    ready_d = !busy_d;
  end

  assign load_ready  = ready_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected issues are queued at start
// and matched against every instr_valid pulse.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [4:0]  load_addr = '0;
  logic [19:0] load_data = '0;
  logic [5:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        abort = 1'b0;
  logic [19:0] instr_out;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .abort       (abort),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] instr;
    logic [4:0]  pc;
    int          cyc;   // 0 = timing not checked
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [19:0] mem_m [32];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Every issue pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && instr_valid) begin
      check("pulse_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_out", 32'(instr_out), 32'(e.instr));
        check("pulse_pc", 32'(pc), 32'(e.pc));
        if (e.cyc != 0) check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic load_word(input int a, input logic [19:0] d);
    @(posedge clk); #1;
    load_valid = 1'b1; load_addr = 5'(a); load_data = d;
    mem_m[a] = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic start_prog(input int len, input int nmax, input bit stepped, output int n0);
    @(posedge clk); #1;
    n0 = cyc; start = 1'b1; prog_len = 6'(len);
    for (int i = 0; i < len && i < nmax; i++) begin
      if (mem_m[i][19:16] == 4'hF) break;
      sb.push_back('{mem_m[i], 5'(i), (stepped && i > 0) ? 0 : n0 + 3 + 5 * i});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check("done_reached", 32'(done), 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  int n0, s0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr_out", 32'(instr_out), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(load_ready), 1);
    rst = 1'b1;

    // Basic free-run program
    load_word(0, 20'h10203);
    load_word(1, 20'h20405);
    load_word(2, 20'h3A0C1);
    start_prog(3, 32, 1'b0, n0);
    check("run_busy", 32'(busy), 1);
    wait_done();
    check("done_cycle", cyc, n0 + 16);
    check("done_pc", 32'(pc), 2);
    check("done_busy", 32'(busy), 0);
    check("sb_empty_basic", sb.size(), 0);

    // Abort during WAIT of instruction 1
    start_prog(3, 2, 1'b0, n0);
    wait_cyc(n0 + 8);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_pc", 32'(pc), 0);
    check("abort_valid", 32'(instr_valid), 0);
    check("abort_instr_hold", 32'(instr_out), 32'h20405);
    repeat (20) @(posedge clk);
    #1;
    check("sb_empty_abort", sb.size(), 0);

    // Zero-length program, then abort+start together in DONE
    start_prog(0, 32, 1'b0, n0);
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 0);
    abort = 1'b1; start = 1'b1; prog_len = 6'd3;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_start_done", 32'(done), 0);
    check("abort_start_busy", 32'(busy), 0);
    check("abort_start_pc", 32'(pc), 0);
    repeat (15) @(posedge clk);
    #1;
    check("abort_start_idle", 32'(busy), 0);

    // Load attempt while running must not reach the RAM
    start_prog(3, 32, 1'b0, n0);
    check("run_not_ready", 32'(load_ready), 0);
    load_valid = 1'b1; load_addr = 5'd0; load_data = 20'hFFFFF;
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_done();
    check("done_ready", 32'(load_ready), 1);
    start_prog(3, 32, 1'b0, n0);
    wait_done();
    check("sb_empty_reload", sb.size(), 0);

    // Single-step, two instructions
    step_mode = 1'b1;
    start_prog(2, 32, 1'b1, n0);
    repeat (20) @(posedge clk);
    #1;
    check("pause_busy", 32'(busy), 1);
    check("pause_pc", 32'(pc), 1);
    check("pause_pending", sb.size(), 1);
    s0 = cyc;
    if (sb.size() != 0) sb[0].cyc = s0 + 3;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    wait_done();
    step_mode = 1'b0;
    check("step_done_pc", 32'(pc), 1);
    check("sb_empty_step", sb.size(), 0);

    // Asynchronous reset in the middle of WAIT
    start_prog(3, 1, 1'b0, n0);
    wait_cyc(n0 + 5);
    #1 rst = 1'b0;
    #1;
    check("arst_instr_out", 32'(instr_out), 0);
    check("arst_valid", 32'(instr_valid), 0);
    check("arst_pc", 32'(pc), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("sb_empty_arst", sb.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    start_prog(3, 32, 1'b0, n0);
    wait_done();
    check("sb_empty_rerun", sb.size(), 0);

    // Halt opcode at address 1
    load_word(1, 20'hF0000);
    load_word(2, 20'h12345);
    load_word(3, 20'h23456);
    load_word(4, 20'h34567);
    start_prog(5, 32, 1'b0, n0);
    wait_done();
    check("halt_pc", 32'(pc), 1);
    check("halt_instr_hold", 32'(instr_out), 32'h10203);
    repeat (5) @(posedge clk);
    #1;
    check("sb_empty_halt", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
